fft_bfly_ctrl: RTL
==================

FFT_BFLY_CTRL -- requirements
Module: fft_bfly_ctrl

Interface
REQ-001 SHALL have parameter BF_LAT, default 2, legal range 1..15: fixed latency in cycles from DO_A/DO_B valid to butterfly result valid on DI_A/DI_B.
REQ-002 SHALL have port Clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port Rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Start  input  1  one-cycle request to run a full 64-point radix-2 DIT pass.
REQ-005 SHALL have port Busy  output  1  high from first READ cycle through last WRITE cycle.
REQ-006 SHALL have port Done  output  1  one-cycle pulse after the final write.
REQ-007 SHALL have port Ram_En  output  1  drives the 64x32 dual-port RAM En.
REQ-008 SHALL have port Ram_We_A  output  1  RAM port A write enable.
REQ-009 SHALL have port Ram_We_B  output  1  RAM port B write enable.
REQ-010 SHALL have port Ram_Addr_A  output  6  RAM port A address (upper butterfly leg).
REQ-011 SHALL have port Ram_Addr_B  output  6  RAM port B address (lower butterfly leg).
REQ-012 SHALL have port Bf_Valid  output  1  DO_A/DO_B hold valid operands this cycle.
REQ-013 SHALL have port Tw_Idx  output  5  twiddle ROM index for the current butterfly.
REQ-014 SHALL have port Stage  output  3  current stage 0..5.

Function
REQ-015 SHALL sequence 6 stages (s=0..5), each 32 butterflies (b=0..31), 192 butterflies total, in that nested order.
REQ-016 SHALL compute, with half=2^s: Ram_Addr_A = (b>>s)*2*half + (b & (half-1)); Ram_Addr_B = Ram_Addr_A + half; Tw_Idx = (b & (half-1)) << (5-s); all results fit their widths, no overflow.
REQ-017 SHALL implement FSM states IDLE, READ, WAIT, WRITE, DONE.
REQ-018 IDLE: Start=1 -> READ next cycle with s=0, b=0; Start=0 -> stay.
REQ-019 READ (one cycle): Ram_En=1, We_A=We_B=0, addresses per REQ-016 -> WAIT.
REQ-020 WAIT: Bf_Valid=1 in the first WAIT cycle only; WAIT lasts exactly BF_LAT cycles, Ram_En=0 -> WRITE.
REQ-021 WRITE (one cycle): Ram_En=1, We_A=We_B=1, same addresses as the preceding READ -> READ of next butterfly, or DONE after butterfly 191.
REQ-022 DONE (one cycle): Done=1, Busy=0 -> IDLE.
REQ-023 Ram_Addr_A/B, Tw_Idx, Stage SHALL be registered and held constant from READ through WRITE of a butterfly.
REQ-024 Timing: with Start sampled at cycle 0, butterfly k READ at cycle 1+k*(BF_LAT+2), Bf_Valid at READ+1, WRITE at (k+1)*(BF_LAT+2), Done at 192*(BF_LAT+2)+1.
REQ-025 Start while not in IDLE SHALL be ignored with no effect on sequencing; Start in the DONE cycle is also ignored.
REQ-026 Ram_We_A/B SHALL never be high while Ram_En is low; outside READ/WRITE Ram_En=0.
REQ-027 Operand bit-reversal ordering is the loader's responsibility; this block performs none.

Reset
REQ-028 Rst_n=0 SHALL immediately force IDLE, s=0, b=0, wait counter 0, and all outputs 0 (Busy, Done, Ram_En, Ram_We_A, Ram_We_B, Bf_Valid, Ram_Addr_A/B, Tw_Idx, Stage).
REQ-029 Reset mid-pass SHALL abandon the pass with no further RAM access; the next Start after release SHALL begin at s=0, b=0.

Verification
REQ-030 BF_LAT=2, Start at cycle 0 -> cycle 1 READ A=0 B=1 Tw=0; cycle 2 Bf_Valid; cycle 4 WRITE A=0 B=1 We_A=We_B=1; cycle 5 READ A=2 B=3.
REQ-031 Full pass BF_LAT=2 -> exactly 192 READ and 192 WRITE cycles, final WRITE at cycle 768 (A=31 B=63 Tw=31 Stage=5), Done pulse at cycle 769 only.
REQ-032 Stage 2, b=5 -> A=9, B=13, Tw_Idx=8; stage 5, b=0 -> A=0, B=32, Tw_Idx=0.
REQ-033 Start re-pulsed at cycles 10 and 769 -> no perturbation of addresses or timing vs REQ-031; Done still at 769.
REQ-034 Rst_n low at cycle 100 for 1 cycle -> all outputs 0 that cycle, no RAM access until new Start; Start at 105 -> READ A=0 B=1 at 106.
REQ-035 BF_LAT=1 and BF_LAT=15 -> Done at cycles 577 and 3265 respectively; Bf_Valid exactly 192 times.

Source files
------------

// File: rtl/fft_bfly_ctrl.sv
// -----------------------------------------------------------------------------
// fft_bfly_ctrl
//
// Address and control sequencer for an in-place 64-point radix-2 DIT FFT.
// It walks 6 stages of 32 butterflies each. For every butterfly it performs
// one RAM read of both legs, waits BF_LAT cycles for the external butterfly
// datapath, then writes both results back to the same two addresses.
// The loader is expected to have stored the operands in bit-reversed order.
// This block does no reordering of its own.
//
// Parameters
//   BF_LAT      : cycles from Bf_Valid to the butterfly result being valid
//                 on the RAM write data inputs (legal range 1..15).
//
// Ports
//   Clk         : single clock, all state updates on the rising edge.
//   Rst_n       : asynchronous active-low reset.
//   Start       : one-cycle request to run a full pass. Sampled only in IDLE.
//   Busy        : high from the first READ cycle through the last WRITE cycle.
//   Done        : one-cycle pulse in the cycle after the final WRITE.
//   Ram_En      : RAM enable. High only in READ and WRITE cycles.
//   Ram_We_A/B  : RAM write enables for ports A and B. High only in WRITE.
//   Ram_Addr_A  : address of the upper butterfly leg.
//   Ram_Addr_B  : address of the lower butterfly leg (Ram_Addr_A + 2^stage).
//   Bf_Valid    : RAM read data holds valid operands this cycle.
//   Tw_Idx      : twiddle ROM index for the current butterfly.
//   Stage       : current stage, 0..5.
// -----------------------------------------------------------------------------
module fft_bfly_ctrl #(
    parameter int unsigned BF_LAT = 2
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Start,
    output logic       Busy,
    output logic       Done,
    output logic       Ram_En,
    output logic       Ram_We_A,
    output logic       Ram_We_B,
    output logic [5:0] Ram_Addr_A,
    output logic [5:0] Ram_Addr_B,
    output logic       Bf_Valid,
    output logic [4:0] Tw_Idx,
    output logic [2:0] Stage
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Value of the wait counter in the last WAIT cycle.
    localparam logic [3:0] WAIT_LAST = 4'(BF_LAT - 1);

    state_t     state_q, state_d;
    logic [2:0] stage_q, stage_d;
    logic [4:0] bfly_q, bfly_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [5:0] addr_a_q, addr_a_d;
    logic [5:0] addr_b_q, addr_b_d;
    logic [4:0] tw_idx_q, tw_idx_d;
    logic       load_addr;

    // Upper-leg address: insert a zero bit at position s into the butterfly
    // number. This equals (b >> s) * 2 * 2^s + (b & (2^s - 1)).
    function automatic logic [5:0] upper_addr(input logic [2:0] s, input logic [4:0] b);
        logic [5:0] b6;
        logic [5:0] mask;
        b6   = {1'b0, b};
        mask = (6'd1 << s) - 6'd1;
        return ((b6 >> s) << (s + 3'd1)) | (b6 & mask);
    endfunction

    // Twiddle index: the position inside the group, scaled up to the 32-entry
    // ROM. The result is always below 32, so the upper bit can be dropped.
    function automatic logic [4:0] twiddle_idx(input logic [2:0] s, input logic [4:0] b);
        logic [5:0] b6;
        logic [5:0] mask;
        logic [5:0] scaled;
        b6     = {1'b0, b};
        mask   = (6'd1 << s) - 6'd1;
        scaled = (b6 & mask) << (3'd5 - s);
        return scaled[4:0];
    endfunction

    // State, loop counters and address registers.
    // The addresses are loaded once per butterfly, on entry to READ. They then
    // stay stable through WAIT and WRITE, so the write lands on the locations
    // that were just read.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            stage_q    <= 3'd0;
            bfly_q     <= 5'd0;
            wait_cnt_q <= 4'd0;
            addr_a_q   <= 6'd0;
            addr_b_q   <= 6'd0;
            tw_idx_q   <= 5'd0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            bfly_q     <= bfly_d;
            wait_cnt_q <= wait_cnt_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            tw_idx_q   <= tw_idx_d;
        end
    end

    // Next-state logic and Moore output decode.
    // Start is only honoured in IDLE. A request arriving mid-pass or in DONE
    // therefore cannot disturb the sequence.
    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        bfly_d     = bfly_q;
        wait_cnt_d = wait_cnt_q;
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        tw_idx_d   = tw_idx_q;
        load_addr  = 1'b0;

        Busy       = 1'b0;
        Done       = 1'b0;
        Ram_En     = 1'b0;
        Ram_We_A   = 1'b0;
        Ram_We_B   = 1'b0;
        Bf_Valid   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d   = ST_READ;
                    stage_d   = 3'd0;
                    bfly_d    = 5'd0;
                    load_addr = 1'b1;
                end
            end

            ST_READ: begin
                Busy       = 1'b1;
                Ram_En     = 1'b1;
                wait_cnt_d = 4'd0;
                state_d    = ST_WAIT;
            end

            ST_WAIT: begin
                Busy     = 1'b1;
                // The read data appears one cycle after READ, which is the
                // first WAIT cycle.
                Bf_Valid = (wait_cnt_q == 4'd0);
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_WRITE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end

            ST_WRITE: begin
                Busy     = 1'b1;
                Ram_En   = 1'b1;
                Ram_We_A = 1'b1;
                Ram_We_B = 1'b1;
                if ((stage_q == 3'd5) && (bfly_q == 5'd31)) begin
                    state_d = ST_DONE;
                end else begin
                    // The butterfly counter wraps to 0 as the stage advances.
                    bfly_d    = bfly_q + 5'd1;
                    stage_d   = (bfly_q == 5'd31) ? stage_q + 3'd1 : stage_q;
                    load_addr = 1'b1;
                    state_d   = ST_READ;
                end
            end

            ST_DONE: begin
                Done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The two legs are always 2^stage apart. Bit 'stage' of the upper
        // address is zero, so setting that bit is the same as adding 2^stage.
        if (load_addr) begin
            addr_a_d = upper_addr(stage_d, bfly_d);
            addr_b_d = upper_addr(stage_d, bfly_d) | (6'd1 << stage_d);
            tw_idx_d = twiddle_idx(stage_d, bfly_d);
        end
    end

    assign Ram_Addr_A = addr_a_q;
    assign Ram_Addr_B = addr_b_q;
    assign Tw_Idx     = tw_idx_q;
    assign Stage      = stage_q;

endmodule
